// File: rtl/cadr_dbg_pkg.sv
// Shared definitions for the CADR debug microinstruction path:
// FSM state encoding, IR widths and spy word slice indices.
package cadr_dbg_pkg;

  localparam int IR_W      = 49;
  localparam int IR_DATA_W = 48;
  localparam int SPY_W     = 16;

  // Bit positions in words_valid / the strobe vector, matching {hi, mid, lo}.
  localparam int WORD_LO  = 0;
  localparam int WORD_MID = 1;
  localparam int WORD_HI  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2
  } state_e;

endpackage

// File: rtl/spy_ir_loader_if.sv
// Spy-bus and processor-side signals of the debug IR loader.
// The loader sits on the slave modport; the spy console/CPU model drives master.
interface spy_ir_loader_if;
  import cadr_dbg_pkg::*;

  logic [SPY_W-1:0] spy_in;
  logic             ldirlo;
  logic             ldirmid;
  logic             ldirhi;
  logic             exec_req;
  logic             cpu_accept;
  logic [IR_W-1:0]  ir_dbg;
  logic             idebug;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       words_valid;

  modport master (
    output spy_in, ldirlo, ldirmid, ldirhi, exec_req, cpu_accept,
    input  ir_dbg, idebug, busy, done, err, words_valid
  );

  modport slave (
    input  spy_in, ldirlo, ldirmid, ldirhi, exec_req, cpu_accept,
    output ir_dbg, idebug, busy, done, err, words_valid
  );

endinterface

// File: rtl/ir_parity_gen.sv
// Parity generator for a microinstruction word; shared with the
// microcode RAM write path so both sides compute the same bit.
module ir_parity_gen #(
  parameter int W = 48
) (
  input  logic [W-1:0] data,
  output logic         parity
);

  // XOR-reduce of the data field; all-zero data yields a 0 parity bit.
  assign parity = ^data;

endmodule

// File: rtl/spy_ir_loader.sv
// Debug-side microinstruction producer: assembles a 48-bit IR from three
// spy writes, issues it with idebug, and times its execution.
module spy_ir_loader
  import cadr_dbg_pkg::*;
#(
  parameter int TIMEOUT     = 1024,
  parameter int EXEC_CYCLES = 2,
  parameter int PARITY_EN   = 1,
  parameter int AUTO_CLEAR  = 1
) (
  input  logic          clk,
  input  logic          reset,
  spy_ir_loader_if.slave bus
);

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] EXEC_INIT = 16'(EXEC_CYCLES - 1);

  state_e           state;
  logic [SPY_W-1:0] word_lo;
  logic [SPY_W-1:0] word_mid;
  logic [SPY_W-1:0] word_hi;
  logic [2:0]       words_valid;
  logic [15:0]      tmo_cnt;
  logic [15:0]      exe_cnt;
  logic             done;
  logic             err;

  logic [2:0]           strobe;
  logic [IR_DATA_W-1:0] ir_data;
  logic                 parity;

  assign strobe  = {bus.ldirhi, bus.ldirmid, bus.ldirlo};
  assign ir_data = {word_hi, word_mid, word_lo};

  ir_parity_gen #(
    .W (IR_DATA_W)
  ) u_parity (
    .data   (ir_data),
    .parity (parity)
  );

  // NOTE: every register here, including the word registers, is cleared by
  // reset so ir_dbg is a known value straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word_lo     <= '0;
      word_mid    <= '0;
      word_hi     <= '0;
      words_valid <= '0;
      tmo_cnt     <= '0;
      exe_cnt     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so the exec_req test below sees the
      // pre-write mask even when a strobe lands in the same cycle.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe[WORD_LO])  word_lo  <= bus.spy_in;
          if (strobe[WORD_MID]) word_mid <= bus.spy_in;
          if (strobe[WORD_HI])  word_hi  <= bus.spy_in;
          words_valid <= words_valid | strobe;
          if (bus.exec_req) begin
            if (words_valid == 3'b111) begin
              state   <= ISSUE;
              tmo_cnt <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Acceptance on the final timeout cycle still wins over the abort.
          if (bus.cpu_accept) begin
            state   <= EXEC;
            exe_cnt <= EXEC_INIT;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
            if (AUTO_CLEAR != 0) words_valid <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        EXEC: begin
          if (exe_cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
            if (AUTO_CLEAR != 0) words_valid <= '0;
          end else begin
            exe_cnt <= exe_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ir_dbg      = {(PARITY_EN != 0) ? parity : 1'b0, ir_data};
  assign bus.idebug      = (state == ISSUE) || (state == EXEC);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done;
  assign bus.err         = err;
  assign bus.words_valid = words_valid;

endmodule

// File: tb/tb_spy_ir_loader.sv
// Self-checking bench for spy_ir_loader: direct checks plus a scoreboard of
// expected done/err completions popped whenever the DUT pulses either.
module tb_spy_ir_loader;
  import cadr_dbg_pkg::*;

  typedef struct packed {
    logic             is_done;
    logic [IR_W-1:0]  ir;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  mon_ev;
  logic [15:0] m_lo, m_mid, m_hi;

  spy_ir_loader_if bus ();

  spy_ir_loader #(
    .TIMEOUT     (8),
    .EXEC_CYCLES (2),
    .PARITY_EN   (1),
    .AUTO_CLEAR  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IR_W-1:0] exp_ir(input logic [15:0] hi, input logic [15:0] mid,
                                             input logic [15:0] lo);
    logic [47:0] d;
    d = {hi, mid, lo};
    return {^d, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [15:0] d);
    bus.spy_in  = d;
    bus.ldirlo  = sel[0];
    bus.ldirmid = sel[1];
    bus.ldirhi  = sel[2];
    tick();
    bus.ldirlo  = 1'b0;
    bus.ldirmid = 1'b0;
    bus.ldirhi  = 1'b0;
    if (sel[0]) m_lo  = d;
    if (sel[1]) m_mid = d;
    if (sel[2]) m_hi  = d;
  endtask

  task automatic pulse_exec();
    bus.exec_req = 1'b1;
    tick();
    bus.exec_req = 1'b0;
  endtask

  // Scoreboard: every done/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (bus.done || bus.err) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {62'd0, bus.done, bus.err}, 64'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("sb_kind", {63'd0, bus.done}, {63'd0, mon_ev.is_done});
        check("sb_kind_err", {63'd0, bus.err}, {63'd0, ~mon_ev.is_done});
        if (mon_ev.is_done) check("sb_ir", {15'd0, bus.ir_dbg}, {15'd0, mon_ev.ir});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.spy_in     = '0;
    bus.ldirlo     = 1'b0;
    bus.ldirmid    = 1'b0;
    bus.ldirhi     = 1'b0;
    bus.exec_req   = 1'b0;
    bus.cpu_accept = 1'b0;
    m_lo = '0; m_mid = '0; m_hi = '0;

    // 1: reset state, full load, issue, accept after 3 cycles
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_idebug", {63'd0, bus.idebug}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_wv", {61'd0, bus.words_valid}, 64'd0);
    check("rst_ir", {15'd0, bus.ir_dbg}, 64'd0);
    wr(3'b001, 16'h1234);
    wr(3'b010, 16'h5678);
    wr(3'b100, 16'h9ABC);
    check("t1_wv", {61'd0, bus.words_valid}, 64'd7);
    check("t1_ir", {15'd0, bus.ir_dbg}, {15'd0, 1'b0, 48'h9ABC_5678_1234});
    exp_q.push_back('{is_done: 1'b1, ir: {1'b0, 48'h9ABC_5678_1234}});
    pulse_exec();
    check("t1_idebug_lat", {63'd0, bus.idebug}, 64'd1);
    tick(); tick();
    bus.cpu_accept = 1'b1;
    tick();
    bus.cpu_accept = 1'b0;
    check("t1_exec_idebug", {63'd0, bus.idebug}, 64'd1);
    tick();
    check("t1_done_early", {63'd0, bus.done}, 64'd0);
    tick();
    check("t1_done", {63'd0, bus.done}, 64'd1);
    check("t1_idebug_off", {63'd0, bus.idebug}, 64'd0);
    check("t1_wv_clr", {61'd0, bus.words_valid}, 64'd0);

    // 2: incomplete mask rejected
    wr(3'b001, 16'h1111);
    wr(3'b010, 16'h2222);
    exp_q.push_back('{is_done: 1'b0, ir: '0});
    pulse_exec();
    check("t2_err", {63'd0, bus.err}, 64'd1);
    check("t2_idebug", {63'd0, bus.idebug}, 64'd0);
    check("t2_wv", {61'd0, bus.words_valid}, 64'd3);
    tick();
    check("t2_err_pulse", {63'd0, bus.err}, 64'd0);

    // 3a: timeout with no accept
    wr(3'b100, 16'h3333);
    exp_q.push_back('{is_done: 1'b0, ir: '0});
    pulse_exec();
    n = 0;
    while (bus.idebug && n < 50) begin
      n++;
      tick();
    end
    check("t3_issue_len", 64'(n), 64'd8);
    check("t3_err", {63'd0, bus.err}, 64'd1);
    check("t3_idle", {63'd0, bus.busy}, 64'd0);
    check("t3_wv_clr", {61'd0, bus.words_valid}, 64'd0);

    // 3b: accept on the final ISSUE cycle wins
    wr(3'b111, 16'(($urandom & 32'hFFFF)));
    wr(3'b001, 16'hA5A5);
    exp_q.push_back('{is_done: 1'b1, ir: exp_ir(m_hi, m_mid, m_lo)});
    pulse_exec();
    repeat (7) tick();
    bus.cpu_accept = 1'b1;
    tick();
    bus.cpu_accept = 1'b0;
    check("t3b_exec", {63'd0, bus.idebug}, 64'd1);
    check("t3b_no_err", {63'd0, bus.err}, 64'd0);
    tick(); tick();
    check("t3b_done", {63'd0, bus.done}, 64'd1);

    // 4: writes and exec_req during ISSUE are ignored
    wr(3'b001, 16'h0F0F);
    wr(3'b010, 16'h7001);
    wr(3'b100, 16'h8421);
    exp_q.push_back('{is_done: 1'b1, ir: exp_ir(m_hi, m_mid, m_lo)});
    pulse_exec();
    bus.spy_in   = 16'hFFFF;
    bus.ldirhi   = 1'b1;
    bus.exec_req = 1'b1;
    tick();
    bus.ldirhi   = 1'b0;
    bus.exec_req = 1'b0;
    check("t4_ir_hold", {15'd0, bus.ir_dbg}, {15'd0, exp_ir(m_hi, m_mid, m_lo)});
    check("t4_wv_hold", {61'd0, bus.words_valid}, 64'd7);
    bus.cpu_accept = 1'b1;
    tick();
    bus.cpu_accept = 1'b0;
    tick(); tick();
    check("t4_done", {63'd0, bus.done}, 64'd1);
    check("t4_wv_clr", {61'd0, bus.words_valid}, 64'd0);
    check("t4_hi_kept", {48'd0, bus.ir_dbg[47:32]}, {48'd0, m_hi});

    // 5: reset during EXEC
    wr(3'b111, 16'hBEEF);
    pulse_exec();
    bus.cpu_accept = 1'b1;
    tick();
    bus.cpu_accept = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_lo = '0; m_mid = '0; m_hi = '0;
    check("t5_idebug", {63'd0, bus.idebug}, 64'd0);
    check("t5_busy", {63'd0, bus.busy}, 64'd0);
    check("t5_wv", {61'd0, bus.words_valid}, 64'd0);
    check("t5_pulses", {62'd0, bus.done, bus.err}, 64'd0);
    check("t5_ir", {15'd0, bus.ir_dbg}, 64'd0);
    tick(); tick();

    // 6: same-cycle write and exec_req judged against the old mask
    wr(3'b001, 16'h4242);
    wr(3'b010, 16'h1357);
    bus.spy_in   = 16'hC3C3;
    bus.ldirhi   = 1'b1;
    bus.exec_req = 1'b1;
    exp_q.push_back('{is_done: 1'b0, ir: '0});
    tick();
    bus.ldirhi   = 1'b0;
    bus.exec_req = 1'b0;
    m_hi = 16'hC3C3;
    check("t6_err", {63'd0, bus.err}, 64'd1);
    check("t6_wv", {61'd0, bus.words_valid}, 64'd7);
    check("t6_idle", {63'd0, bus.idebug}, 64'd0);
    exp_q.push_back('{is_done: 1'b1, ir: exp_ir(m_hi, m_mid, m_lo)});
    pulse_exec();
    check("t6_issue", {63'd0, bus.idebug}, 64'd1);
    bus.cpu_accept = 1'b1;
    tick();
    bus.cpu_accept = 1'b0;
    tick(); tick();
    check("t6_done", {63'd0, bus.done}, 64'd1);
    tick();

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
